gf2m_reduce_81: RTL and testbench

//   Reduces the 161-bit unreduced GF(2)[x] product from the 81-bit Karatsuba multiplier into a GF(2^81) element.

---
 rtl/gf2m_pkg.sv | 24 ++
 rtl/gf2m_fold.sv | 32 +++
 rtl/gf2m_reduce_81.sv | 93 +++++++++
 tb/tb_gf2m_reduce_81.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gf2m_pkg                                                     |
// | Description : Field constants and types for GF(2^81) reduction modulo      |
// |               the trinomial x^M + x^K + 1.                                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package gf2m_pkg;

  localparam int M      = 81;
  localparam int K      = 4;
  localparam int PROD_W = 2*M-1;
  localparam int S1_W   = M+K-1;

  typedef logic [M-1:0]      gf_elem_t;
  typedef logic [PROD_W-1:0] gf_prod_t;

  // x^M == x^K + 1, so every high coefficient folds back onto bits i and i+K.
  function automatic logic [S1_W-1:0] fold(input logic [M-2:0] hi, input logic [M-1:0] lo);
    fold = {{(K-1){1'b0}}, lo} ^ {{K{1'b0}}, hi} ^ {hi, {K{1'b0}}};
  endfunction

endpackage : gf2m_pkg
`default_nettype wire

// File: rtl/gf2m_fold.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gf2m_fold                                                    |
// | Description : One combinational trinomial fold step: lo ^ hi ^ (hi<<SHIFT)|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module gf2m_fold #(
  parameter int HI_W  = 80,
  parameter int LO_W  = 81,
  parameter int SHIFT = 4,
  parameter int OUT_W = 84
) (
  input  logic [HI_W-1:0]  i_hi,
  input  logic [LO_W-1:0]  i_lo,
  output logic [OUT_W-1:0] o_fold
);

  generate
    if (OUT_W < LO_W || OUT_W < HI_W + SHIFT) begin : g_width_err
      $error("gf2m_fold: OUT_W too narrow for the fold result");
    end
  endgenerate

  always_comb begin
    o_fold                         = '0;
    o_fold[LO_W-1:0]               = i_lo;
    o_fold[HI_W-1:0]               = o_fold[HI_W-1:0] ^ i_hi;
    o_fold[HI_W+SHIFT-1:SHIFT]     = o_fold[HI_W+SHIFT-1:SHIFT] ^ i_hi;
  end

endmodule : gf2m_fold
`default_nettype wire

// File: rtl/gf2m_reduce_81.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gf2m_reduce_81                                               |
// | Description : Two-stage pipelined reduction of a 161-bit GF(2)[x] product  |
// |               into GF(2^81), valid/ready on both sides, 2-cycle latency.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module gf2m_reduce_81
  import gf2m_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [M-1:0]      o_out_data
);

  generate
    if (K < 1 || K > (M-1)/2) begin : g_k_range_err
      $error("gf2m_reduce_81: K outside 1..(M-1)/2, two folds are not enough");
    end
  endgenerate

  logic            r_s1_valid;
  logic            r_s2_valid;
  logic [S1_W-1:0] r_s1;
  gf_elem_t        r_s2;

  logic            w_s1_adv;
  logic            w_s2_adv;
  logic            w_in_acc;
  logic [S1_W-1:0] w_fold1;
  gf_elem_t        w_fold2;

  // Ready depends only on downstream state and out_ready, never on in_valid.
  assign w_s2_adv   = !r_s2_valid || i_out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_in_acc   = i_in_valid && w_s1_adv;
  assign o_in_ready = w_s1_adv;

  gf2m_fold #(
    .HI_W  (M-1),
    .LO_W  (M),
    .SHIFT (K),
    .OUT_W (S1_W)
  ) u_fold1 (
    .i_hi   (i_in_data[PROD_W-1:M]),
    .i_lo   (i_in_data[M-1:0]),
    .o_fold (w_fold1)
  );

  gf2m_fold #(
    .HI_W  (K-1),
    .LO_W  (M),
    .SHIFT (K),
    .OUT_W (M)
  ) u_fold2 (
    .i_hi   (r_s1[S1_W-1:M]),
    .i_lo   (r_s1[M-1:0]),
    .o_fold (w_fold2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= i_in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // Stage-1 data is only ever consumed behind r_s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_in_acc) r_s1 <= w_fold1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_s2 <= w_fold2;
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_out_data  = r_s2;

endmodule : gf2m_reduce_81
`default_nettype wire

// File: tb/tb_gf2m_reduce_81.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gf2m_reduce_81                                            |
// | Description : Self-checking bench for gf2m_reduce_81 with a bit-serial     |
// |               polynomial reduction reference model.                        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_gf2m_reduce_81;

  logic         clk;
  logic         rst_n;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [160:0] i_in_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [80:0]  o_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  gf2m_reduce_81 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Long division by x^81 + x^4 + 1, one coefficient at a time from the top.
  function automatic logic [80:0] ref_reduce(input logic [160:0] d);
    logic [160:0] r;
    r = d;
    for (int i = 160; i >= 81; i--) begin
      if (r[i]) begin
        r[i]          = 1'b0;
        r[i - 81 + 4] = ~r[i - 81 + 4];
        r[i - 81]     = ~r[i - 81];
      end
    end
    return r[80:0];
  endfunction

  function automatic logic [160:0] rand_prod();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[160:0];
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    #2;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
    n_checks++;
    if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", o_in_ready); end
    n_checks++;
    if (o_out_data !== 81'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", o_out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [160:0] dv [3];
    logic [80:0]  ev [3];
    logic [80:0]  pass_val;
    pass_val = 81'h1_2345_6789_ABCD_EF01_2345;
    dv[0] = '0; dv[0][81]  = 1'b1;
    dv[1] = '0; dv[1][160] = 1'b1;
    dv[2] = {80'h0, pass_val};
    ev[0] = 81'h11;
    ev[1] = 81'h0_8000_0000_0000_0000_0044;
    ev[2] = pass_val;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      i_in_valid = 1'b1; i_in_data = dv[v]; i_out_ready = 1'b1;
      #1;
      n_checks++;
      if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL directed%0d_in_ready: got %b want 1", v, o_in_ready); end
      @(negedge clk);
      i_in_valid = 1'b0;
      #1;
      n_checks++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL directed%0d_early_valid: got %b want 0", v, o_out_valid); end
      @(negedge clk);
      #1;
      n_checks++;
      if (o_out_valid !== 1'b1 || o_out_data !== ev[v]) begin
        n_fail++;
        $display("FAIL directed%0d_result: got valid=%b data=%h want valid=1 data=%h", v, o_out_valid, o_out_data, ev[v]);
      end
    end
  endtask

  task automatic test_stream(input bit rnd);
    logic [160:0] din [100];
    logic [80:0]  exp_q [$];
    logic [80:0]  exp_v;
    logic [80:0]  last;
    int  sent, got, cyc;
    bit  stalled, ir_ok;
    for (int i = 0; i < 100; i++) din[i] = rand_prod();
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; ir_ok = 1'b1; last = '0;
    while (got < 100 && cyc < 2000) begin
      @(negedge clk);
      i_in_valid  = (sent < 100);
      i_in_data   = (sent < 100) ? din[sent] : '0;
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== last) begin
          n_fail++;
          $display("FAIL stream_stall_hold: got valid=%b data=%h want valid=1 data=%h", o_out_valid, o_out_data, last);
        end
      end
      if (o_out_valid && i_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_output: got data=%h want no output", o_out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (o_out_data !== exp_v) begin
            n_fail++;
            $display("FAIL stream_beat%0d: got %h want %h", got, o_out_data, exp_v);
          end
        end
        got++;
      end
      if (i_in_valid && o_in_ready) begin
        exp_q.push_back(ref_reduce(din[sent]));
        sent++;
      end
      if (!rnd && i_in_valid && !o_in_ready) ir_ok = 1'b0;
      stalled = o_out_valid && !i_out_ready;
      last    = o_out_data;
      cyc++;
    end
    n_checks++;
    if (got != 100 || sent != 100) begin
      n_fail++;
      $display("FAIL stream_count: got sent=%0d received=%0d want 100/100", sent, got);
    end
    if (!rnd) begin
      n_checks++;
      if (cyc != 102 || !ir_ok) begin
        n_fail++;
        $display("FAIL stream_throughput: got cycles=%0d in_ready_ok=%0d want 102/1", cyc, ir_ok);
      end
    end
    @(negedge clk);
    i_in_valid = 1'b0; i_out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got valid=%b want 0", o_out_valid); end
  endtask

  task automatic test_backpressure();
    logic [160:0] a, b, c;
    logic [80:0]  ea, eb, ec;
    a = rand_prod(); b = rand_prod(); c = rand_prod();
    ea = ref_reduce(a); eb = ref_reduce(b); ec = ref_reduce(c);
    @(negedge clk);
    i_in_valid = 1'b1; i_in_data = a; i_out_ready = 1'b0;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a: got in_ready=%b want 1", o_in_ready); end
    @(negedge clk);
    i_in_data = b;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b: got in_ready=%b want 1", o_in_ready); end
    @(negedge clk);
    i_in_data = c;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== ea) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b valid=%b data=%h want 0/1/%h", o_in_ready, o_out_valid, o_out_data, ea);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== ea) begin
        n_fail++;
        $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h want 0/1/%h", o_in_ready, o_out_valid, o_out_data, ea);
      end
    end
    @(negedge clk);
    i_out_ready = 1'b1;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b1 || o_out_data !== ea) begin
      n_fail++;
      $display("FAIL bp_accept_and_drain: got in_ready=%b valid=%b data=%h want 1/1/%h", o_in_ready, o_out_valid, o_out_data, ea);
    end
    @(negedge clk);
    i_in_valid = 1'b0; i_out_ready = 1'b0;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== eb) begin
      n_fail++;
      $display("FAIL bp_occupancy: got in_ready=%b valid=%b data=%h want 0/1/%h", o_in_ready, o_out_valid, o_out_data, eb);
    end
    @(negedge clk);
    i_out_ready = 1'b1;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== eb) begin
      n_fail++;
      $display("FAIL bp_drain_b: got valid=%b data=%h want 1/%h", o_out_valid, o_out_data, eb);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== ec) begin
      n_fail++;
      $display("FAIL bp_drain_c: got valid=%b data=%h want 1/%h", o_out_valid, o_out_data, ec);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid=%b want 0", o_out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [160:0] a, b, c;
    logic [80:0]  ec;
    a = rand_prod(); b = rand_prod(); c = rand_prod();
    ec = ref_reduce(c);
    @(negedge clk);
    i_in_valid = 1'b1; i_in_data = a; i_out_ready = 1'b1;
    @(negedge clk);
    i_in_data = b;
    @(negedge clk);
    i_in_valid = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight: got valid=%b want 1", o_out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_data !== 81'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid=%b in_ready=%b data=%h want 0/1/0", o_out_valid, o_in_ready, o_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got valid=%b want 0", o_out_valid); end
    @(negedge clk);
    i_in_valid = 1'b1; i_in_data = c;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_new_accept: got in_ready=%b valid=%b want 1/0", o_in_ready, o_out_valid);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got valid=%b data=%h want 0", o_out_valid, o_out_data); end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== ec) begin
      n_fail++;
      $display("FAIL rstmid_new_beat: got valid=%b data=%h want 1/%h", o_out_valid, o_out_data, ec);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got valid=%b want 0", o_out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(1'b0);
    test_stream(1'b1);
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gf2m_reduce_81
`default_nettype wire
